// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared constants for the UART receive FIFO slave:
//   - register indices decoded from adr_i[3:2]
//   - STATUS / CTRL bit positions
//   - the word returned by a DATA read of an empty FIFO
//   - sat8(): clamps a 9-bit fill level into the 8-bit STATUS count field
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    localparam int ST_EMPTY   = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_OVERRUN = 2;
    localparam int ST_TIMEOUT = 3;

    localparam int CTRL_FLUSH = 8;

    localparam logic [31:0] EMPTY_READ = 32'h0000_0100;

    // A 256-entry FIFO can hold 256 bytes, which does not fit in 8 bits.
    function automatic logic [7:0] sat8(input logic [8:0] value);
        return (value > 9'd255) ? 8'hFF : value[7:0];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with simultaneous push/pop and a synchronous flush.
//   clk      in   clock, rising edge
//   srst     in   synchronous active-high reset
//   flush    in   return pointers and count to 0; overrides push and pop
//   push     in   write wr_data (accepted when not full, or when popping)
//   pop      in   advance the read pointer (ignored when empty)
//   wr_data  in   WIDTH-bit write data
//   rd_data  out  head entry (combinational from the array)
//   count    out  fill level, AW+1 bits
//   full     out  count == DEPTH
//   empty    out  count == 0
// The head is read asynchronously; the consumer registers it on its side.
// ---------------------------------------------------------------------------
module sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       srst,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wr_data,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full  = (count_reg == CW'(DEPTH));
    assign empty = (count_reg == '0);
    assign count = count_reg;

    // A pop on a full FIFO frees the slot the simultaneous push needs.
    assign pop_ok  = pop && !empty && !flush;
    assign push_ok = push && !flush && (!full || pop_ok);

    assign rd_data = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (srst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// Receive buffer behind the UART deserialiser, drained over a single-cycle
// strobe/ack slave bus.
//   sys_clk  in   clock, rising edge
//   sys_rst  in   synchronous active-high reset
//   rx_data  in   received byte, valid while rx_done=1
//   rx_done  in   one-cycle strobe: push rx_data
//   dat_i    in   bus write data
//   adr_i    in   bus byte address, adr_i[3:2] selects DATA/STATUS/CTRL/rsvd
//   we_i     in   bus write enable
//   stb_i    in   bus strobe, held until ack_o
//   dat_o    out  bus read data, valid while ack_o=1
//   ack_o    out  one-cycle acknowledge
//   irq      out  level interrupt: threshold reached, overrun or timeout
// Optional feature macro: UART_RXFIFO_TIMEOUT_EN builds an idle counter that
// raises a sticky timeout flag after TIMEOUT_CYCLES idle cycles with data
// waiting in the FIFO.
// ---------------------------------------------------------------------------
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH          = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_done,
    input  logic [31:0] dat_i,
    input  logic [31:0] adr_i,
    input  logic        we_i,
    input  logic        stb_i,
    output logic [31:0] dat_o,
    output logic        ack_o,
    output logic        irq
);

    localparam int AW = $clog2(DEPTH);

    logic          ack_reg;
    logic [31:0]   dat_reg;
    logic [7:0]    thresh_reg;
    logic          overrun_reg;
    logic          timeout;

    logic          access;
    logic [1:0]    reg_idx;
    logic          pop;
    logic          flush;
    logic          ctrl_write;
    logic          status_w1c;
    logic          overrun_set;
    logic [7:0]    head;
    logic [AW:0]   count;
    logic [8:0]    count_ext;
    logic          full;
    logic          empty;
    logic [31:0]   status_word;
    logic [31:0]   rd_word;

    // While ack_o is high the held strobe belongs to the access just
    // acknowledged, so it must not be accepted a second time.
    assign access     = stb_i && !ack_reg;
    assign reg_idx    = adr_i[3:2];
    assign pop        = access && !we_i && (reg_idx == REG_DATA) && !empty;
    assign ctrl_write = access && we_i && (reg_idx == REG_CTRL);
    assign status_w1c = access && we_i && (reg_idx == REG_STATUS);
    assign flush      = ctrl_write && dat_i[CTRL_FLUSH];
    assign overrun_set = rx_done && full && !pop && !flush;
    assign count_ext  = 9'(count);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (sys_clk),
        .srst    (sys_rst),
        .flush   (flush),
        .push    (rx_done),
        .pop     (pop),
        .wr_data (rx_data),
        .rd_data (head),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    always_comb begin
        status_word             = '0;
        status_word[15:8]       = sat8(count_ext);
        status_word[ST_TIMEOUT] = timeout;
        status_word[ST_OVERRUN] = overrun_reg;
        status_word[ST_FULL]    = full;
        status_word[ST_EMPTY]   = empty;
    end

    always_comb begin
        rd_word = '0;
        case (reg_idx)
            REG_DATA:   rd_word = empty ? EMPTY_READ : {24'h0, head};
            REG_STATUS: rd_word = status_word;
            REG_CTRL:   rd_word = {24'h0, thresh_reg};
            default:    rd_word = '0;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            ack_reg     <= 1'b0;
            dat_reg     <= '0;
            thresh_reg  <= 8'd1;
            overrun_reg <= 1'b0;
        end else begin
            ack_reg <= access;
            if (access) begin
                dat_reg <= rd_word;
            end
            if (ctrl_write) begin
                thresh_reg <= dat_i[7:0];
            end
            // A fresh overrun wins over a clear issued on the same edge.
            if (overrun_set) begin
                overrun_reg <= 1'b1;
            end else if (status_w1c && dat_i[ST_OVERRUN]) begin
                overrun_reg <= 1'b0;
            end
        end
    end

`ifdef UART_RXFIFO_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

    logic [IW-1:0] idle_reg;
    logic          timeout_reg;
    logic          idle_clear;

    assign idle_clear = rx_done || pop || (count == '0);

    // The counter saturates, and the flag is set only on the step that
    // reaches the limit, so clearing timeout does not immediately re-raise it.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            idle_reg    <= '0;
            timeout_reg <= 1'b0;
        end else begin
            if (idle_clear) begin
                idle_reg <= '0;
            end else if (idle_reg != IW'(TIMEOUT_CYCLES)) begin
                idle_reg <= idle_reg + IW'(1);
            end
            if (!idle_clear && (idle_reg == IW'(TIMEOUT_CYCLES - 1))) begin
                timeout_reg <= 1'b1;
            end else if (status_w1c && dat_i[ST_TIMEOUT]) begin
                timeout_reg <= 1'b0;
            end
        end
    end

    assign timeout = timeout_reg;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    logic unused_bus;
    assign unused_bus = ^{adr_i[31:4], adr_i[1:0], dat_i[31:9]};

    assign irq   = ((thresh_reg != 8'd0) && (count_ext >= {1'b0, thresh_reg}))
                   || overrun_reg || timeout;
    assign ack_o = ack_reg;
    assign dat_o = dat_reg;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
// Self-checking bench for uart_rx_fifo (DEPTH=16, TIMEOUT_CYCLES=64). A
// queue-based reference model tracks the stored bytes, flags and threshold.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
    localparam int TO    = 64;
    localparam logic [1:0] I_DATA = 2'd0, I_STAT = 2'd1, I_CTRL = 2'd2, I_RSVD = 2'd3;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic [31:0] dat_i;
    logic [31:0] adr_i;
    logic        we_i;
    logic        stb_i;
    logic [31:0] dat_o;
    logic        ack_o;
    logic        irq;

    int checks = 0;
    int errors = 0;

    logic [7:0] model_q[$];
    logic       model_overrun;
    logic       model_timeout;
    logic [7:0] model_thresh;

    always #5 sys_clk = ~sys_clk;

    uart_rx_fifo #(
        .DEPTH          (DEPTH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .rx_data (rx_data),
        .rx_done (rx_done),
        .dat_i   (dat_i),
        .adr_i   (adr_i),
        .we_i    (we_i),
        .stb_i   (stb_i),
        .dat_o   (dat_o),
        .ack_o   (ack_o),
        .irq     (irq)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        s = 32'h0;
        s[15:8] = 8'(model_q.size());
        s[3] = model_timeout;
        s[2] = model_overrun;
        s[1] = (model_q.size() == DEPTH);
        s[0] = (model_q.size() == 0);
        return s;
    endfunction

    function automatic logic exp_irq();
        return ((model_thresh != 0) && (model_q.size() >= int'(model_thresh)))
               || model_overrun || model_timeout;
    endfunction

    function automatic void model_push(input logic [7:0] b);
        if (model_q.size() < DEPTH) model_q.push_back(b);
        else model_overrun = 1'b1;
    endfunction

    function automatic logic [31:0] model_read_data();
        if (model_q.size() == 0) return 32'h0000_0100;
        return {24'h0, model_q.pop_front()};
    endfunction

    // ---------------- drivers ----------------
    task automatic bus(input logic we, input logic [1:0] idx, input logic [31:0] wd,
                       input logic push_en, input logic [7:0] push_b,
                       output logic [31:0] rd, output logic ack_hi, output logic ack_lo);
        stb_i = 1'b1; we_i = we; adr_i = {28'h0, idx, 2'b00}; dat_i = wd;
        rx_done = push_en; rx_data = push_b;
        @(posedge sys_clk); #1;
        ack_hi = ack_o; rd = dat_o;
        stb_i = 1'b0; we_i = 1'b0; rx_done = 1'b0;
        @(posedge sys_clk); #1;
        ack_lo = ack_o;
        $display("bus we=%0d idx=%0d wd=%h push=%0d/%h rd=%h ack=%0d%0d",
                 we, idx, wd, push_en, push_b, rd, ack_hi, ack_lo);
    endtask

    task automatic rd_reg(input logic [1:0] idx, output logic [31:0] rd);
        logic a1, a0;
        bus(1'b0, idx, 32'h0, 1'b0, 8'h00, rd, a1, a0);
    endtask

    task automatic wr_reg(input logic [1:0] idx, input logic [31:0] wd);
        logic [31:0] rd;
        logic a1, a0;
        bus(1'b1, idx, wd, 1'b0, 8'h00, rd, a1, a0);
    endtask

    task automatic push(input logic [7:0] b);
        rx_done = 1'b1; rx_data = b;
        @(posedge sys_clk); #1;
        rx_done = 1'b0;
        $display("push %h", b);
    endtask

    task automatic drain_all(input string tag);
        logic [31:0] rd, ex;
        while (model_q.size() > 0) begin
            ex = model_read_data();
            rd_reg(I_DATA, rd);
            checks++;
            if (rd !== ex) begin errors++; $display("FAIL %s_drain: got %h expected %h", tag, rd, ex); end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [31:0] rd;
        sys_rst = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 32'h0; dat_i = 32'h0;
        rx_done = 1'b1; rx_data = 8'h77;
        repeat (3) @(posedge sys_clk);
        #1;
        checks++; if (ack_o !== 1'b0) begin errors++; $display("FAIL rst_ack: got %b expected 0", ack_o); end
        checks++; if (dat_o !== 32'h0) begin errors++; $display("FAIL rst_dat: got %h expected 0", dat_o); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b expected 0", irq); end
        stb_i = 1'b0; rx_done = 1'b0;
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        model_q.delete(); model_overrun = 1'b0; model_timeout = 1'b0; model_thresh = 8'd1;
        @(posedge sys_clk); #1;
        checks++; if (ack_o !== 1'b0) begin errors++; $display("FAIL post_rst_ack: got %b expected 0", ack_o); end
        rd_reg(I_STAT, rd);
        checks++; if (rd !== 32'h1) begin errors++; $display("FAIL rst_status: got %h expected 00000001", rd); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq2: got %b expected 0", irq); end
        rd_reg(I_CTRL, rd);
        checks++; if (rd !== 32'h1) begin errors++; $display("FAIL rst_ctrl: got %h expected 00000001", rd); end
        rd_reg(I_DATA, rd);
        checks++; if (rd !== 32'h100) begin errors++; $display("FAIL empty_read: got %h expected 00000100", rd); end
        rd_reg(I_RSVD, rd);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rsvd_read: got %h expected 0", rd); end
        rd_reg(I_STAT, rd);
        checks++; if (rd !== 32'h1) begin errors++; $display("FAIL empty_read_nopop: got %h expected 00000001", rd); end
    endtask

    task automatic test_basic();
        logic [7:0] pat[3];
        logic [31:0] rd, ex;
        logic a1, a0;
        pat = '{8'h55, 8'hAA, 8'h0F};
        for (int i = 0; i < 3; i++) begin
            push(pat[i]); model_push(pat[i]);
            if (i == 0) begin
                checks++; if (irq !== 1'b1) begin errors++; $display("FAIL basic_irq_first: got %b expected 1", irq); end
            end
        end
        for (int i = 0; i < 3; i++) begin
            ex = model_read_data();
            bus(1'b0, I_DATA, 32'h0, 1'b0, 8'h00, rd, a1, a0);
            checks++; if (rd !== ex) begin errors++; $display("FAIL basic_read%0d: got %h expected %h", i, rd, ex); end
            checks++; if (a1 !== 1'b1 || a0 !== 1'b0) begin errors++; $display("FAIL basic_ack%0d: got %b%b expected 10", i, a1, a0); end
        end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL basic_irq_drained: got %b expected 0", irq); end
        rd_reg(I_DATA, rd);
        checks++; if (rd !== 32'h100) begin errors++; $display("FAIL basic_empty: got %h expected 00000100", rd); end
    endtask

    task automatic test_overrun();
        logic [31:0] rd, ex;
        for (int i = 0; i < DEPTH + 1; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            push(b); model_push(b);
        end
        rd_reg(I_STAT, rd); ex = exp_status();
        checks++; if (rd !== ex || rd !== 32'h1006) begin errors++; $display("FAIL ovr_status: got %h expected %h", rd, ex); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL ovr_irq: got %b expected 1", irq); end
        wr_reg(I_STAT, 32'h4); model_overrun = 1'b0;
        rd_reg(I_STAT, rd); ex = exp_status();
        checks++; if (rd !== ex) begin errors++; $display("FAIL ovr_clear: got %h expected %h", rd, ex); end
        checks++; if (irq !== exp_irq()) begin errors++; $display("FAIL ovr_irq_after_clear: got %b expected %b", irq, exp_irq()); end
        drain_all("ovr");
    endtask

    task automatic test_push_pop_full();
        logic [31:0] rd, ex;
        logic a1, a0;
        for (int i = 0; i < DEPTH; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            push(b); model_push(b);
        end
        ex = model_read_data(); model_push(8'hC3);
        bus(1'b0, I_DATA, 32'h0, 1'b1, 8'hC3, rd, a1, a0);
        checks++; if (rd !== ex) begin errors++; $display("FAIL pp_read: got %h expected %h", rd, ex); end
        rd_reg(I_STAT, rd); ex = exp_status();
        checks++; if (rd !== ex || rd !== 32'h1002) begin errors++; $display("FAIL pp_status: got %h expected %h", rd, ex); end
        checks++; if (model_q[DEPTH-1] !== 8'hC3) begin errors++; $display("FAIL pp_model_tail: got %h expected c3", model_q[DEPTH-1]); end
        drain_all("pp");
    endtask

    task automatic test_flush();
        logic [31:0] rd, ex;
        logic a1, a0;
        int n[2];
        n = '{5, DEPTH + 1};
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < n[k]; i++) begin
                logic [7:0] b;
                b = 8'($urandom);
                push(b); model_push(b);
            end
            bus(1'b1, I_CTRL, 32'h100, 1'b1, 8'($urandom), rd, a1, a0);
            model_q.delete(); model_thresh = 8'd0;
            rd_reg(I_STAT, rd); ex = exp_status();
            checks++; if (rd !== ex) begin errors++; $display("FAIL flush%0d_status: got %h expected %h", k, rd, ex); end
            checks++; if (irq !== exp_irq()) begin errors++; $display("FAIL flush%0d_irq: got %b expected %b", k, irq, exp_irq()); end
            rd_reg(I_CTRL, rd);
            checks++; if (rd !== 32'h0) begin errors++; $display("FAIL flush%0d_ctrl: got %h expected 0", k, rd); end
            rd_reg(I_DATA, rd);
            checks++; if (rd !== 32'h100) begin errors++; $display("FAIL flush%0d_empty: got %h expected 00000100", k, rd); end
            wr_reg(I_CTRL, 32'h1); model_thresh = 8'd1;
            wr_reg(I_STAT, 32'h4); model_overrun = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, ex0, ex1;
        logic [3:0] acks;
        logic [31:0] d1, d3;
        for (int i = 0; i < 3; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            push(b); model_push(b);
        end
        ex0 = model_read_data(); ex1 = model_read_data();
        stb_i = 1'b1; we_i = 1'b0; adr_i = 32'h0;
        d1 = 32'h0; d3 = 32'h0;
        for (int c = 0; c < 4; c++) begin
            @(posedge sys_clk); #1;
            acks[c] = ack_o;
            if (c == 0) d1 = dat_o;
            if (c == 2) d3 = dat_o;
        end
        stb_i = 1'b0;
        $display("b2b acks=%b d1=%h d3=%h", acks, d1, d3);
        checks++; if (acks !== 4'b0101) begin errors++; $display("FAIL b2b_acks: got %b expected 0101", acks); end
        checks++; if (d1 !== ex0) begin errors++; $display("FAIL b2b_first: got %h expected %h", d1, ex0); end
        checks++; if (d3 !== ex1) begin errors++; $display("FAIL b2b_second: got %h expected %h", d3, ex1); end
        @(posedge sys_clk); #1;
        rd_reg(I_STAT, rd);
        checks++; if (rd !== exp_status()) begin errors++; $display("FAIL b2b_status: got %h expected %h", rd, exp_status()); end
        drain_all("b2b");
    endtask

    task automatic test_random();
        logic [31:0] rd, ex, wd;
        int op;
        for (int t = 0; t < 300; t++) begin
            op = $urandom_range(0, 11);
            if (op <= 4) begin
                logic [7:0] b;
                b = 8'($urandom);
                push(b); model_push(b);
            end else if (op <= 7) begin
                ex = model_read_data();
                rd_reg(I_DATA, rd);
                checks++; if (rd !== ex) begin errors++; $display("FAIL rnd_data t=%0d: got %h expected %h", t, rd, ex); end
            end else if (op == 8) begin
                ex = exp_status();
                rd_reg(I_STAT, rd);
                checks++; if (rd !== ex) begin errors++; $display("FAIL rnd_status t=%0d: got %h expected %h", t, rd, ex); end
            end else if (op == 9) begin
                wd = {23'h0, ($urandom_range(0, 7) == 0), 8'($urandom_range(0, 20))};
                wr_reg(I_CTRL, wd);
                model_thresh = wd[7:0];
                if (wd[8]) model_q.delete();
            end else if (op == 10) begin
                wd = 32'($urandom_range(0, 15)) << 2;
                wr_reg(I_STAT, wd);
                if (wd[2]) model_overrun = 1'b0;
                if (wd[3]) model_timeout = 1'b0;
            end else begin
                ex = {24'h0, model_thresh};
                rd_reg(I_CTRL, rd);
                checks++; if (rd !== ex) begin errors++; $display("FAIL rnd_ctrl t=%0d: got %h expected %h", t, rd, ex); end
            end
            checks++; if (irq !== exp_irq()) begin errors++; $display("FAIL rnd_irq t=%0d: got %b expected %b", t, irq, exp_irq()); end
        end
        wr_reg(I_CTRL, 32'h101); model_q.delete(); model_thresh = 8'd1;
        wr_reg(I_STAT, 32'hC);   model_overrun = 1'b0; model_timeout = 1'b0;
    endtask

    task automatic test_timeout();
        logic [31:0] rd, ex;
        wr_reg(I_CTRL, 32'h8); model_thresh = 8'd8;
        for (int i = 0; i < 2; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            push(b); model_push(b);
        end
        repeat (40) @(posedge sys_clk);
        #1;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL to_early_irq: got %b expected 0", irq); end
        repeat (30) @(posedge sys_clk);
        #1;
`ifdef UART_RXFIFO_TIMEOUT_EN
        model_timeout = 1'b1;
`endif
        checks++; if (irq !== exp_irq()) begin errors++; $display("FAIL to_irq: got %b expected %b", irq, exp_irq()); end
        rd_reg(I_STAT, rd); ex = exp_status();
        checks++; if (rd !== ex) begin errors++; $display("FAIL to_status: got %h expected %h", rd, ex); end
        wr_reg(I_STAT, 32'h8); model_timeout = 1'b0;
        rd_reg(I_STAT, rd); ex = exp_status();
        checks++; if (rd !== ex) begin errors++; $display("FAIL to_clear: got %h expected %h", rd, ex); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL to_irq_clear: got %b expected 0", irq); end
        drain_all("to");
        wr_reg(I_CTRL, 32'h1); model_thresh = 8'd1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_push_pop_full();
        test_flush();
        test_back_to_back();
        test_random();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side buffer placed directly downstream of the `uart` block. It captures each byte the UART deserialiser completes and queues it in a FIFO, so the CPU does not have to service every byte before the next one arrives. The CPU drains the queue through the same single-cycle strobe/ack slave bus used by `uart`. A level interrupt tells the CPU when the fill level reaches a threshold or the queue has overflowed.

## Interface
- DEPTH, 16, FIFO entries; must be a power of two, from 4 to 256.
- AW, $clog2(DEPTH), pointer width; derived, never overridden.
- TIMEOUT_CYCLES, 4096, idle cycles before the timeout flag is set (used only with the macro).

- sys_clk  in  1  clock; all logic on the rising edge.
- sys_rst  in  1  synchronous, active-high reset.
- rx_data  in  8  byte from the UART receiver; valid only while rx_done=1.
- rx_done  in  1  one-cycle strobe: rx_data holds a new byte.
- dat_i  in  32  bus write data.
- adr_i  in  32  bus byte address; only adr_i[3:2] is decoded.
- we_i  in  1  bus write enable.
- stb_i  in  1  bus strobe; held high until ack_o is seen.
- dat_o  out  32  bus read data; valid while ack_o=1.
- ack_o  out  1  one-cycle acknowledge.
- irq  out  1  level interrupt to the CPU.

## Operation
- Registers, selected by adr_i[3:2]:
  - 0 DATA (R). Read returns {23'b0, empty, byte}. If the FIFO is not empty, the read pops one entry. If it is empty, the read returns 0x0000_0100 and pops nothing. Writes are ignored.
  - 1 STATUS (R/W1C). Read returns {16'b0, count[7:0], 4'b0, timeout, overrun, full, empty}. Writing 1 to bit 2 clears overrun; writing 1 to bit 3 clears timeout.
  - 2 CTRL (R/W). Bits [7:0] hold thresh; a value of 0 disables the level interrupt. Writing 1 to bit 8 flushes the FIFO; this bit is self-clearing and always reads 0.
  - 3 reserved. Reads return 0; writes are ignored.
- Push: rx_done=1 with count<DEPTH writes rx_data at wr_ptr, then wr_ptr++ (wraps modulo DEPTH) and count++.
- Push while full: the byte is dropped, overrun is set (sticky), and the FIFO contents are unchanged.
- Push and pop in the same cycle: both take effect and count is unchanged. This also applies when full: the pop frees a slot, so the push is accepted and no overrun is raised.
- Flush: pointers and count return to 0. A push in the same cycle as a flush is discarded. The overrun and timeout flags are not affected.
- irq = (thresh!=0 && count>=thresh) | overrun | timeout.
- count is AW+1 bits wide. In the STATUS read it is zero-extended to 8 bits; when DEPTH=256 it saturates at 0xFF.

## Timing
- An access is accepted on the edge where stb_i=1 and ack_o=0.
  - At that edge: ack_o<=1, dat_o<=the addressed value, and any pop, W1C or CTRL write takes effect.
  - ack_o always returns to 0 on the next edge.
  - If stb_i stays high, the next access is accepted one cycle later, giving at most one access per 2 cycles.
  - Each access produces exactly one pop.
- Read latency is one cycle. DATA is sampled before the pop.
- A byte pushed at edge N is readable by an access accepted at edge N+1 or later.
- Status flags and irq are registered or derived from registered state; irq updates one cycle after the causing event.
- Values during and after reset:
  - ack_o=0 and dat_o=0.
  - irq=0, count=0, pointers=0.
  - overrun=0, timeout=0, thresh=1.
  - Reset takes priority over all other inputs. A bus access in flight during reset is dropped with no ack_o.

## Configuration
- UART_RXFIFO_TIMEOUT_EN defined:
  - An idle counter counts cycles while count>0 and rx_done=0.
  - The counter clears on any push, any pop, or when count==0.
  - When it reaches TIMEOUT_CYCLES, timeout is set (sticky).
- UART_RXFIFO_TIMEOUT_EN undefined: no counter is built, STATUS bit 3 reads 0, and timeout never contributes to irq.

## Structure
- uart_pkg holds:
  - register index constants (REG_DATA=0, REG_STATUS=1, REG_CTRL=2);
  - STATUS and CTRL bit positions;
  - the empty-read value 32'h0000_0100.
- Sub-module sync_fifo (parameters WIDTH, DEPTH): storage, pointers, count, full and empty, with simultaneous push and pop.
- uart_rx_fifo itself contains the bus decode, flags, threshold logic and the optional timeout counter.

## Test plan
- After reset, read STATUS: expect 0x0000_0001 and irq=0. Read DATA: expect 0x0000_0100, count stays 0.
- Push 0x55, 0xAA, 0x0F, then read DATA three times: expect 0x55, 0xAA, 0x0F in order, then empty. irq=1 after the first push (thresh=1) and back to 0 after the third read.
- Push 17 bytes into DEPTH=16: expect full=1, overrun=1, irq=1, and the 17th byte lost. Write STATUS=0x4: overrun clears, but irq stays 1 because count=16 >= thresh=1.
- Fill to 16 entries, then assert rx_done with byte 0xC3 on the same edge a DATA read is accepted. Expect count=16 and no overrun; 0xC3 is read last.
- Write CTRL=0x100 with 5 entries queued: count=0 and empty=1 next cycle. A push on the flush edge is discarded.
- With UART_RXFIFO_TIMEOUT_EN, TIMEOUT_CYCLES=64 and thresh=8: push 2 bytes, wait 64 idle cycles, expect timeout=1 and irq=1. Without the macro, STATUS bit 3 stays 0.
